// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle between the run controller, the instruction ROM and the datapath/decoder.
// FETCH_CYCLE_CNT_EN adds the cycle_cnt field.
interface fetch_ctrl_if;
    logic       start;
    logic       stall;
    logic [8:0] inst_in;
    logic       br_abs;
    logic       br_rel;
    logic [7:0] br_target;
    logic [7:0] br_offset;
    logic [7:0] PC;
    logic [8:0] inst_out;
    logic       running;
    logic       done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;

    modport slave  (input  start, stall, inst_in, br_abs, br_rel, br_target, br_offset,
                    output PC, inst_out, running, done, cycle_cnt);
    modport master (output start, stall, inst_in, br_abs, br_rel, br_target, br_offset,
                    input  PC, inst_out, running, done, cycle_cnt);
`else
    modport slave  (input  start, stall, inst_in, br_abs, br_rel, br_target, br_offset,
                    output PC, inst_out, running, done);
    modport master (output start, stall, inst_in, br_abs, br_rel, br_target, br_offset,
                    input  PC, inst_out, running, done);
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// PC/fetch sequencer with IDLE/RUN/HALTED run control, stall hold and halt detection.
// Optional FETCH_CYCLE_CNT_EN adds a saturating count of cycles spent in RUN.
module fetch_ctrl #(
    parameter logic [7:0] START_ADDR = 8'd0,
    parameter logic [8:0] HALT_WORD  = 9'h1FF
) (
    input  logic          CLK,
    input  logic          reset,
    fetch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= S_IDLE;
            pc_q      <= START_ADDR;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef FETCH_CYCLE_CNT_EN
            cycle_cnt_q <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef FETCH_CYCLE_CNT_EN
            cycle_cnt_q <= cycle_cnt_d;
`endif
        end
    end

    // Next-state and PC update
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (bus.inst_in == HALT_WORD) begin
                        state_d = S_HALTED;
                    end else if (bus.br_abs) begin
                        pc_d = bus.br_target;
                    end else if (bus.br_rel) begin
                        // Sign extension to 8 bits is the identity, so a plain 8-bit add wraps correctly.
                        pc_d = pc_q + bus.br_offset;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FETCH_CYCLE_CNT_EN
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == S_RUN) begin
            if (cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
        end else if (bus.start) begin
            cycle_cnt_d = 16'd0;
        end
    end
    assign bus.cycle_cnt = cycle_cnt_q;
`endif

    // Outputs: running/done are registered decodes of the next state
    always_comb begin
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_HALTED);
    end

    assign bus.PC       = pc_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.inst_out = running_q ? bus.inst_in : HALT_WORD;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; define FETCH_CYCLE_CNT_EN to also exercise cycle_cnt.
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.START_ADDR(8'd0), .HALT_WORD(9'h1FF)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Jump to an address with an absolute branch (only meaningful in RUN).
    task automatic jump(input logic [7:0] a);
        bus.br_abs    = 1'b1;
        bus.br_target = a;
        step(1);
        bus.br_abs    = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++; if (bus.PC !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", bus.PC); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", bus.running); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.inst_out !== 9'h1FF) begin errors++; $display("FAIL reset_inst_out: got %0h want 1ff", bus.inst_out); end
        step(3);
        checks++; if (bus.PC !== 8'd0 || bus.running !== 1'b0) begin errors++; $display("FAIL idle_hold: pc %0h run %b want 0/0", bus.PC, bus.running); end
    endtask

    task automatic test_sequential();
        logic [7:0] exp_pc;
        bus.inst_in = 9'h0A5;
        start_pulse();
        checks++; if (bus.PC !== 8'd0 || bus.running !== 1'b1) begin errors++; $display("FAIL start_run: pc %0h run %b want 0/1", bus.PC, bus.running); end
        checks++; if (bus.inst_out !== 9'h0A5) begin errors++; $display("FAIL inst_pass: got %0h want 0a5", bus.inst_out); end
        for (int i = 1; i <= 3; i++) begin
            step(1);
            exp_pc = 8'(i);
            checks++; if (bus.PC !== exp_pc) begin errors++; $display("FAIL seq_pc%0d: got %0h want %0h", i, bus.PC, exp_pc); end
        end
    endtask

    task automatic test_branch();
        step(2);
        checks++; if (bus.PC !== 8'd5) begin errors++; $display("FAIL seq_pc5: got %0h want 5", bus.PC); end
        jump(8'd8);
        checks++; if (bus.PC !== 8'd8) begin errors++; $display("FAIL br_abs: got %0h want 8", bus.PC); end
        jump(8'd7);
        bus.br_rel = 1'b1; bus.br_offset = 8'hFD;
        step(1);
        bus.br_rel = 1'b0;
        checks++; if (bus.PC !== 8'd4) begin errors++; $display("FAIL br_rel_neg: got %0h want 4", bus.PC); end
        jump(8'd3);
        bus.br_abs = 1'b1; bus.br_target = 8'h20; bus.br_rel = 1'b1; bus.br_offset = 8'h05;
        step(1);
        bus.br_abs = 1'b0; bus.br_rel = 1'b0;
        checks++; if (bus.PC !== 8'h20) begin errors++; $display("FAIL br_both: got %0h want 20", bus.PC); end
    endtask

    task automatic test_wrap();
        jump(8'hFF);
        step(1);
        checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL wrap_inc: got %0h want 0", bus.PC); end
        jump(8'h02);
        bus.br_rel = 1'b1; bus.br_offset = 8'hF0;
        step(1);
        checks++; if (bus.PC !== 8'hF2) begin errors++; $display("FAIL wrap_rel_neg: got %0h want f2", bus.PC); end
        bus.br_offset = 8'h20;
        step(1);
        bus.br_rel = 1'b0;
        checks++; if (bus.PC !== 8'h12) begin errors++; $display("FAIL wrap_rel_pos: got %0h want 12", bus.PC); end
    endtask

    task automatic test_stall();
        jump(8'h04);
        bus.stall = 1'b1; bus.br_abs = 1'b1; bus.br_target = 8'h40;
        for (int i = 0; i < 3; i++) begin
            bus.inst_in = (i == 1) ? 9'h1FF : 9'h0A5;
            step(1);
            checks++; if (bus.PC !== 8'h04 || bus.running !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: pc %0h run %b want 4/1", i, bus.PC, bus.running); end
        end
        bus.inst_in = 9'h0A5;
        bus.stall = 1'b0;
        step(1);
        bus.br_abs = 1'b0;
        checks++; if (bus.PC !== 8'h40) begin errors++; $display("FAIL stall_release: got %0h want 40", bus.PC); end
        start_pulse();
        checks++; if (bus.PC !== 8'h41 || bus.running !== 1'b1) begin errors++; $display("FAIL start_in_run: pc %0h run %b want 41/1", bus.PC, bus.running); end
    endtask

    task automatic test_halt();
        jump(8'h09);
        bus.inst_in = 9'h1FF;
        bus.br_abs = 1'b1; bus.br_target = 8'h33;
        step(1);
        checks++; if (bus.done !== 1'b1 || bus.running !== 1'b0 || bus.PC !== 8'h09) begin
            errors++; $display("FAIL halt_enter: done %b run %b pc %0h want 1/0/09", bus.done, bus.running, bus.PC); end
        bus.inst_in = 9'h0A5;
        checks++; if (bus.inst_out !== 9'h1FF) begin errors++; $display("FAIL halt_inst_out: got %0h want 1ff", bus.inst_out); end
        for (int i = 0; i < 10; i++) begin
            bus.br_abs = i[0]; bus.br_rel = ~i[0]; bus.br_offset = 8'h11;
            step(1);
            checks++; if (bus.PC !== 8'h09 || bus.done !== 1'b1) begin errors++; $display("FAIL halt_hold%0d: pc %0h done %b want 09/1", i, bus.PC, bus.done); end
        end
        bus.br_abs = 1'b0; bus.br_rel = 1'b0;
        start_pulse();
        checks++; if (bus.PC !== 8'h00 || bus.done !== 1'b0 || bus.running !== 1'b1) begin
            errors++; $display("FAIL halt_restart: pc %0h done %b run %b want 0/0/1", bus.PC, bus.done, bus.running); end
    endtask

    task automatic test_reset_mid_run();
        jump(8'h06);
        checks++; if (bus.PC !== 8'h06) begin errors++; $display("FAIL pre_reset_pc: got %0h want 6", bus.PC); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (bus.PC !== 8'h00 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL mid_reset: pc %0h run %b done %b want 0/0/0", bus.PC, bus.running, bus.done); end
        step(2);
        checks++; if (bus.PC !== 8'h00 || bus.running !== 1'b0) begin errors++; $display("FAIL post_reset_idle: pc %0h run %b want 0/0", bus.PC, bus.running); end
    endtask

`ifdef FETCH_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        bus.inst_in = 9'h0A5;
        start_pulse();
        checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL cnt_start: got %0d want 0", bus.cycle_cnt); end
        step(8);
        bus.stall = 1'b1;
        step(3);
        bus.stall = 1'b0;
        bus.inst_in = 9'h1FF;
        step(1);
        bus.inst_in = 9'h0A5;
        checks++; if (bus.cycle_cnt !== 16'd12 || bus.done !== 1'b1) begin
            errors++; $display("FAIL cnt_halt: cnt %0d done %b want 12/1", bus.cycle_cnt, bus.done); end
        step(4);
        checks++; if (bus.cycle_cnt !== 16'd12) begin errors++; $display("FAIL cnt_hold: got %0d want 12", bus.cycle_cnt); end
        start_pulse();
        checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL cnt_restart: got %0d want 0", bus.cycle_cnt); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", bus.cycle_cnt); end
    endtask
`endif

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.inst_in   = 9'h000;
        bus.br_abs    = 1'b0;
        bus.br_rel    = 1'b0;
        bus.br_target = 8'h00;
        bus.br_offset = 8'h00;

        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_stall();
        test_halt();
        test_reset_mid_run();
`ifdef FETCH_CYCLE_CNT_EN
        test_cycle_cnt();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Program-counter and fetch sequencer that drives the 8-bit PC into the instruction ROM and consumes its 9-bit instruction word. It owns the IDLE/RUN/HALTED run control, sequential and branch PC update (absolute and relative), stall hold and halt detection. It sits between the instruction ROM and the datapath/decoder of the 9-bit CPU.

Parameters:
START_ADDR, 8'd0, PC value loaded on reset and on every start.
HALT_WORD, 9'h1FF, instruction encoding recognised as halt (all ones).

Ports:
CLK  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins execution from IDLE or HALTED.
stall  input  1  holds PC and state while high in RUN.
inst_in  input  9  instruction word from ROM at current PC (combinational lookup).
br_abs  input  1  datapath: absolute branch taken for current instruction.
br_rel  input  1  datapath: relative branch taken for current instruction.
br_target  input  8  absolute target (from branch LUT).
br_offset  input  8  signed two's-complement relative offset (from branch LUT).
PC  output  8  program counter to ROM.
inst_out  output  9  instruction to decoder.
running  output  1  high while state is RUN.
done  output  1  high while state is HALTED.

Behaviour:
- Clocking fixed: one clock CLK; reset synchronous, active-high.
- Reset (takes priority over everything, including mid-RUN): state=IDLE, PC=START_ADDR, running=0, done=0.
- States: IDLE, RUN, HALTED. running and done are registered decodes of state.
- IDLE: PC holds. start=1 -> RUN next edge, PC=START_ADDR.
- RUN, per edge, in priority order:
  1. stall=1: PC and state hold; branch/halt inputs ignored.
  2. inst_in==HALT_WORD: -> HALTED, PC holds (points at halt), branch inputs ignored.
  3. br_abs=1: PC<=br_target (br_abs wins if br_abs and br_rel are both high).
  4. br_rel=1: PC<=PC+sign_ext(br_offset), modulo 256.
  5. else PC<=PC+1, modulo 256 (255 -> 0).
- start is ignored while in RUN.
- HALTED: PC holds; start=1 -> RUN, PC=START_ADDR, done cleared on the same edge.
- inst_out = inst_in when running=1, else HALT_WORD; the decoder therefore never sees a live instruction outside RUN.
- Latency: branch decisions take effect on the next edge; the target instruction appears on inst_out in the following cycle. There are no delay slots.
- All PC arithmetic is 8-bit with wrap-around; no overflow flag.

Optional Feature:
FETCH_CYCLE_CNT_EN: when defined, adds output cycle_cnt [15:0].
- Counts every edge spent in RUN, including stalled cycles.
- Cleared to 0 by reset and by the start edge that enters RUN.
- Saturates at 16'hFFFF.
- Holds its value in HALTED and IDLE.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset asserted 2 cycles, then released -> PC=0, running=0, done=0, inst_out=9'h1FF. Start pulse, then non-branch words -> PC sequence 0,1,2,3; running=1.
- At PC=5 with br_abs=1, br_target=8 -> PC=8 next edge. At PC=7 with br_rel=1, br_offset=8'hFD (-3) -> PC=4. At PC=3 with both br_abs and br_rel high, br_target=0x20 and br_offset=0x05 -> PC=0x20.
- PC=255 with no branch -> PC=0. PC=2 with br_rel and br_offset=8'hF0 -> PC=0xF2.
- stall high for 3 cycles at PC=4 with br_abs=1 -> PC stays 4 throughout. After stall drops -> PC=br_target.
- inst_in=9'h1FF at PC=9 -> done=1, running=0 next edge; PC holds 9 for 10+ cycles with branches toggling. Start pulse -> PC=0, done=0, running=1.
- reset pulsed while running at PC=6 -> next edge PC=0, IDLE, running=0. With FETCH_CYCLE_CNT_EN: 12 RUN cycles including 3 stalled, then halt -> cycle_cnt=12 and holds.
